// File: rtl/monster_ctrl_pkg.sv
// Shared tile/move codes, FSM states and sprite constants
// for the monster controller and its neighbours.
package monster_ctrl_pkg;

  localparam int SPRITE_LEN     = 32;
  localparam int SPRITE_SHIFT   = 5;
  localparam int WALK_DELAY_DEF = 5;

  localparam logic [2:0] MAP_ROAD0  = 3'd0;
  localparam logic [2:0] MAP_ROAD1  = 3'd1;
  localparam logic [2:0] MAP_WALL   = 3'd2;
  localparam logic [2:0] MAP_STAIRS = 3'd3;

  typedef enum logic [2:0] {
    MOVE_STOP  = 3'd0,
    MOVE_DOWN  = 3'd1,
    MOVE_UP    = 3'd2,
    MOVE_LEFT  = 3'd3,
    MOVE_RIGHT = 3'd4
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_MOVE,
    ST_DEAD
  } state_t;

  function automatic logic is_road(
    input logic [2:0] t
  );
    return (t == MAP_ROAD0) ||
           (t == MAP_ROAD1);
  endfunction

  function automatic move_t dir_to_move(
    input logic [1:0] d
  );
    move_t m;
    m = MOVE_STOP;
    unique case (1'b1)
      (d == 2'd0): m = MOVE_DOWN;
      (d == 2'd1): m = MOVE_UP;
      (d == 2'd2): m = MOVE_LEFT;
      (d == 2'd3): m = MOVE_RIGHT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/monster_ctrl_if.sv
// Tile-map probe port: controller drives dest_r/dest_c,
// map answers dest_type combinationally in the same cycle.
interface monster_ctrl_if;
  import monster_ctrl_pkg::*;

  logic [9:0] dest_r;
  logic [9:0] dest_c;
  logic [2:0] dest_type;

  modport master (
    output dest_r,
    output dest_c,
    input  dest_type
  );

  modport slave (
    input  dest_r,
    input  dest_c,
    output dest_type
  );

endinterface

// File: rtl/monster_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, free running.
// Ports: clk_13, rst (async low), state_o.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_13,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic        fb_d;

  assign fb_d = lfsr_q[15] ^ lfsr_q[13] ^
                lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_13 or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], fb_d};
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/monster_ctrl.sv
// Monster0 wander/health controller: idles, probes a random
// neighbour tile, slides one tile, loses hp on player contact.
// Ports: clk_13, rst, player_*, mp (map probe), monster_*,
// move_stat, hp.
module monster_ctrl
  import monster_ctrl_pkg::*;
#(
  parameter int          START_R     = 5,
  parameter int          START_C     = 5,
  parameter int          HP_FULL     = 3,
  parameter int          WAIT_CYCLES = 4096,
  parameter int          WALK_DELAY  = WALK_DELAY_DEF,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic           clk_13,
  input  logic           rst,
  input  logic [9:0]     player_r,
  input  logic [9:0]     player_c,
  input  logic           player_alive,
  monster_ctrl_if.master mp,
  output logic [9:0]     monster_r,
  output logic [9:0]     monster_c,
  output logic [9:0]     monster_v,
  output logic [9:0]     monster_h,
  output logic           monster_alive,
  output logic [2:0]     move_stat,
  output logic [4:0]     hp
);

  localparam int MW = WALK_DELAY + 6;
  localparam int WW = $clog2(WAIT_CYCLES);
  localparam logic [WW-1:0] WAIT_LD =
    WW'(WAIT_CYCLES - 1);
  localparam logic [9:0] R0 = 10'(START_R);
  localparam logic [9:0] C0 = 10'(START_C);
  localparam logic [9:0] V0 =
    10'(START_R * SPRITE_LEN);
  localparam logic [9:0] H0 =
    10'(START_C * SPRITE_LEN);

  state_t        st_q;
  move_t         stat_q;
  logic [9:0]    r_q, c_q, v_q, h_q;
  logic [4:0]    hp_q;
  logic [1:0]    dir_q;
  logic [WW-1:0] wait_q;
  logic [MW-1:0] mcnt_q;
  logic [19:0]   prv_q;

  logic [15:0]   lfsr;
  logic          lfsr_unused;
  logic [1:0]    dir_d;
  logic [9:0]    dest_r_d, dest_c_d;
  logic          hit, kill, step;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_13  (clk_13),
    .rst     (rst),
    .state_o (lfsr)
  );

  assign dir_d       = lfsr[1:0];
  assign lfsr_unused = ^lfsr[15:2];

  always_comb begin
    dest_r_d = r_q;
    dest_c_d = c_q;
    unique case (dir_d)
      2'd0: dest_r_d = r_q + 10'd1;
      2'd1: dest_r_d = r_q - 10'd1;
      2'd2: dest_c_d = c_q - 10'd1;
      2'd3: dest_c_d = c_q + 10'd1;
    endcase
  end

  assign mp.dest_r = (st_q == ST_PROBE) ?
                     dest_r_d : r_q;
  assign mp.dest_c = (st_q == ST_PROBE) ?
                     dest_c_d : c_q;

  // Edge-triggered: only a fresh arrival on our tile hurts.
  assign hit  = player_alive && monster_alive &&
                ({player_r, player_c} != prv_q) &&
                ({player_r, player_c} == {r_q, c_q});
  assign kill = hit && (hp_q == 5'd1);
  assign step = (mcnt_q[WALK_DELAY:0] == '0);

  // Tracks the player even while held in reset.
  always_ff @(posedge clk_13) begin
    prv_q <= {player_r, player_c};
  end

  always_ff @(posedge clk_13 or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_IDLE;
      stat_q <= MOVE_STOP;
      r_q    <= R0;
      c_q    <= C0;
      v_q    <= V0;
      h_q    <= H0;
      hp_q   <= 5'(HP_FULL);
      dir_q  <= 2'd0;
      wait_q <= WAIT_LD;
      mcnt_q <= '0;
    end else begin
      if (hit) begin
        hp_q <= hp_q - 5'd1;
      end
      unique case (st_q)
        ST_IDLE: begin
          if (wait_q == '0) begin
            st_q <= ST_PROBE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ST_PROBE: begin
          if (is_road(mp.dest_type)) begin
            r_q    <= dest_r_d;
            c_q    <= dest_c_d;
            dir_q  <= dir_d;
            mcnt_q <= '1;
            stat_q <= dir_to_move(dir_d);
            st_q   <= ST_MOVE;
          end else begin
            wait_q <= WAIT_LD;
            st_q   <= ST_IDLE;
          end
        end
        ST_MOVE: begin
          mcnt_q <= mcnt_q - 1'b1;
          if (step && !kill) begin
            case (dir_q)
              2'd0:    v_q <= v_q + 10'd1;
              2'd1:    v_q <= v_q - 10'd1;
              2'd2:    h_q <= h_q - 10'd1;
              default: h_q <= h_q + 10'd1;
            endcase
          end
          if (mcnt_q == '0) begin
            stat_q <= MOVE_STOP;
            wait_q <= WAIT_LD;
            st_q   <= ST_IDLE;
          end
        end
        ST_DEAD: begin
        end
      endcase
      // Death overrides any move in flight; sprite freezes.
      if (kill) begin
        st_q   <= ST_DEAD;
        stat_q <= MOVE_STOP;
      end
    end
  end

  assign monster_r     = r_q;
  assign monster_c     = c_q;
  assign monster_v     = v_q;
  assign monster_h     = h_q;
  assign hp            = hp_q;
  assign monster_alive = (hp_q != 5'd0);
  assign move_stat     = stat_q;

endmodule

// File: tb/tb_monster_ctrl.sv
// Random + directed bench for monster_ctrl against a
// tile/slide reference model.
module tb_monster_ctrl;
  import monster_ctrl_pkg::*;

  localparam int WAIT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pr = 10'd0;
  logic [9:0] pc = 10'd0;
  logic       pal = 1'b1;
  logic [9:0] mr, mc, mv, mh;
  logic       malive;
  logic [2:0] mstat;
  logic [4:0] hp;

  int map_mode = 0;
  int salt = 0;
  int pmode = 0;
  int prate = 64;
  int n_chk = 0;
  int n_pass = 0;
  bit probe_seen;

  monster_ctrl_if mif ();

  monster_ctrl #(
    .START_R     (5),
    .START_C     (5),
    .HP_FULL     (3),
    .WAIT_CYCLES (WAIT),
    .WALK_DELAY  (5),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk_13        (clk),
    .rst           (rst_n),
    .player_r      (pr),
    .player_c      (pc),
    .player_alive  (pal),
    .mp            (mif),
    .monster_r     (mr),
    .monster_c     (mc),
    .monster_v     (mv),
    .monster_h     (mh),
    .monster_alive (malive),
    .move_stat     (mstat),
    .hp            (hp)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] map_fn(
    input logic [9:0] r,
    input logic [9:0] c,
    input int         mode,
    input int         s
  );
    logic [31:0] h;
    logic [2:0]  t;
    h = ({12'd0, r, c} ^ s) * 32'h9E3779B1;
    t = h[17:15];
    case (mode)
      0:       return MAP_ROAD0;
      1:       return MAP_ROAD1;
      2:       return MAP_WALL;
      default: return (t < 3'd5) ? {2'b00, t[0]} : t;
    endcase
  endfunction

  assign mif.dest_type =
    map_fn(mif.dest_r, mif.dest_c, map_mode, salt);

  // reference model
  int          m_mode;
  int          m_tmr, m_k, m_dir, m_hp;
  logic [9:0]  m_r, m_c, m_v, m_h, m_bv, m_bh;
  logic [2:0]  m_stat;
  logic [15:0] m_lf;
  logic [19:0] m_prv;

  function automatic logic [19:0] nb(
    input logic [1:0] d,
    input logic [9:0] r,
    input logic [9:0] c
  );
    case (d)
      2'd0:    return {r + 10'd1, c};
      2'd1:    return {r - 10'd1, c};
      2'd2:    return {r, c - 10'd1};
      default: return {r, c + 10'd1};
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_tmr  = WAIT - 1;
    m_k    = 0;
    m_dir  = 0;
    m_hp   = 3;
    m_r    = 10'd5;
    m_c    = 10'd5;
    m_v    = 10'd160;
    m_h    = 10'd160;
    m_bv   = 10'd160;
    m_bh   = 10'd160;
    m_stat = 3'd0;
    m_lf   = 16'hACE1;
    m_prv  = {pr, pc};
  endtask

  task automatic model_step();
    logic [19:0] d;
    logic [9:0]  off;
    bit          hit, kill;
    hit  = pal && (m_hp > 0) && ({pr, pc} != m_prv) &&
           ({pr, pc} == {m_r, m_c});
    kill = hit && (m_hp == 1);
    case (m_mode)
      0: begin
        if (m_tmr == 0) m_mode = 1;
        else m_tmr--;
      end
      1: begin
        d = nb(m_lf[1:0], m_r, m_c);
        if (map_fn(d[19:10], d[9:0], map_mode, salt)
            <= 3'd1) begin
          m_dir  = int'(m_lf[1:0]);
          m_bv   = m_v;
          m_bh   = m_h;
          m_r    = d[19:10];
          m_c    = d[9:0];
          m_k    = 0;
          m_stat = 3'(m_dir + 1);
          m_mode = 2;
        end else begin
          m_tmr  = WAIT - 1;
          m_mode = 0;
        end
      end
      2: begin
        if (!kill) begin
          off = 10'((m_k + 1) / 64);
          case (m_dir)
            0:       m_v = m_bv + off;
            1:       m_v = m_bv - off;
            2:       m_h = m_bh - off;
            default: m_h = m_bh + off;
          endcase
        end
        if (m_k == 2047) begin
          m_mode = 0;
          m_tmr  = WAIT - 1;
          m_stat = 3'd0;
        end else begin
          m_k++;
        end
      end
      default: ;
    endcase
    if (hit) m_hp--;
    if (kill) begin
      m_mode = 3;
      m_stat = 3'd0;
    end
    m_prv = {pr, pc};
    m_lf  = {m_lf[14:0],
             m_lf[15] ^ m_lf[13] ^ m_lf[12] ^ m_lf[10]};
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cmp_all();
    logic [19:0] ed;
    ed = (m_mode == 1) ? nb(m_lf[1:0], m_r, m_c)
                       : {m_r, m_c};
    chk("row", 32'(mr), 32'(m_r));
    chk("col", 32'(mc), 32'(m_c));
    chk("pix_v", 32'(mv), 32'(m_v));
    chk("pix_h", 32'(mh), 32'(m_h));
    chk("stat", 32'(mstat), 32'(m_stat));
    chk("hp", 32'(hp), 32'(m_hp));
    chk("alive", 32'(malive), 32'(m_hp != 0));
    chk("dest_r", 32'(mif.dest_r), 32'(ed[19:10]));
    chk("dest_c", 32'(mif.dest_c), 32'(ed[9:0]));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_step();
      else m_prv = {pr, pc};
      @(negedge clk);
      cmp_all();
      probe_seen = (mif.dest_r != mr) ||
                   (mif.dest_c != mc);
      if (pmode == 1 &&
          $urandom_range(0, prate - 1) == 0) begin
        pr  = m_r + 10'($urandom_range(0, 2)) - 10'd1;
        pc  = m_c + 10'($urandom_range(0, 2)) - 10'd1;
        pal = ($urandom_range(0, 7) != 0);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_r"}, 32'(mr), 32'd5);
    chk({tag, "_c"}, 32'(mc), 32'd5);
    chk({tag, "_v"}, 32'(mv), 32'd160);
    chk({tag, "_h"}, 32'(mh), 32'd160);
    chk({tag, "_hp"}, 32'(hp), 32'd3);
    chk({tag, "_alive"}, 32'(malive), 32'd1);
    chk({tag, "_stat"}, 32'(mstat), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset("rst");
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_probe(input string tag);
    int cnt;
    cnt = 0;
    probe_seen = 1'b0;
    while (!probe_seen && cnt < 200) begin
      run(1);
      cnt++;
    end
    chk(tag, 32'(cnt), 32'(WAIT));
  endtask

  task automatic count_probes(
    input string tag, input int n, input int exp
  );
    int cnt;
    cnt = 0;
    repeat (n) begin
      run(1);
      if (probe_seen) cnt++;
    end
    chk(tag, 32'(cnt), 32'(exp));
  endtask

  task automatic step_on(input bit alive_in);
    pal = alive_in;
    pr  = 10'd5;
    pc  = 10'd5;
    run(1);
  endtask

  initial begin
    @(negedge clk);
    // reset, open map, first probe latency, slides
    map_mode = 0;
    do_reset();
    wait_probe("probe_lat");
    run(4500);
    map_mode = 1;
    run(2200);

    // walls: no movement, one probe per period
    map_mode = 2;
    do_reset();
    count_probes("wall_probes", 10 * (WAIT + 1), 10);
    chk("wall_row", 32'(mr), 32'd5);

    // three fresh steps kill it
    pr = 10'd5;
    pc = 10'd4;
    do_reset();
    run(3);
    for (int i = 0; i < 3; i++) begin
      step_on(1'b1);
      chk("hp_step", 32'(hp), 32'(2 - i));
      pc = 10'd4;
      run(2);
    end
    chk("dead_alive", 32'(malive), 32'd0);
    count_probes("dead_probes", 60, 0);

    // no repeat damage; dead player does no damage
    pr = 10'd5;
    pc = 10'd4;
    do_reset();
    run(2);
    step_on(1'b1);
    run(20);
    chk("hold_hp", 32'(hp), 32'd2);
    pc = 10'd4;
    run(2);
    step_on(1'b0);
    run(2);
    chk("pdead_hp", 32'(hp), 32'd2);
    pal = 1'b1;
    run(3);
    chk("held_hp", 32'(hp), 32'd2);

    // reset in the middle of a slide
    map_mode = 0;
    do_reset();
    run(WAIT + 600);
    chk("mid_move", 32'(mstat != 3'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("mrst");
    model_reset();
    run(2);
    rst_n = 1'b1;
    wait_probe("probe_lat2");

    // random maps and wandering player
    map_mode = 3;
    pmode = 1;
    for (int rd = 0; rd < 6; rd++) begin
      salt  = int'($urandom);
      prate = int'($urandom_range(48, 512));
      pal   = 1'b1;
      do_reset();
      run(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
